// File: rtl/sonar_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sonar_sequencer
// Description : HC-SR04 measurement sequencer. Issues trigger pulses, times
//               the synchronised echo with a prescaler so that distance in mm
//               is counted directly (no divider), guards each measurement with
//               an echo timeout and inserts a holdoff before the next trigger.
//               Optional feature macro: SONAR_HOLD_LAST_EN. When it is defined,
//               a timeout keeps the previous dist_mm and in_range.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_sequencer #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_MM  = 291,
  parameter int ECHO_TIMEOUT   = 1250000,
  parameter int HOLDOFF_CYCLES = 3000000,
  parameter int MIN_MM         = 20,
  parameter int MAX_MM         = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] dist_mm,
  output logic        dist_valid,
  output logic        in_range,
  output logic        timeout,
  output logic        busy
);

  // One phase counter serves TRIG, the echo timeout and HOLDOFF; the phases
  // never overlap, so it is sized for the longest of the three.
  localparam int CNT_MAX_A = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > HOLDOFF_CYCLES) ? CNT_MAX_A : HOLDOFF_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int PS_W      = (CYCLES_PER_MM > 1) ? $clog2(CYCLES_PER_MM) : 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(CYCLES_PER_MM - 1);
  localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);

  // The cycle in which the rising edge is detected already has echo high, so
  // it is counted as the first echo cycle: this makes the counted width equal
  // the pin width exactly.
  localparam logic [PS_W-1:0]  PS_RISE   = (CYCLES_PER_MM > 1) ? PS_W'(1) : PS_W'(0);
  localparam logic [11:0]      MM_RISE   = (CYCLES_PER_MM > 1) ? 12'd0 : 12'd1;
  localparam logic [11:0]      MM_SAT    = 12'hFFF;
  localparam logic [11:0]      MIN_V     = 12'(MIN_MM);
  localparam logic [11:0]      MAX_V     = 12'(MAX_MM);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic [11:0]        mm_q, mm_d;
  logic [11:0]        dist_q, dist_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               in_range_q, in_range_d;
  logic               timeout_q, timeout_d;
  logic               echo_meta_q, echo_s_q, echo_dly_q;
  logic               w_rise, w_fall, w_to_hit, w_to_evt;

  // Two-flop synchroniser for the asynchronous echo pin plus one delay stage
  // (echo_dly_q) used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_dly_q  <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_dly_q  <= echo_s_q;
    end
  end

  assign w_rise   = echo_s_q & ~echo_dly_q;
  assign w_fall   = ~echo_s_q & echo_dly_q;
  assign w_to_hit = (cnt_q == TO_LAST);

  // Next-state, counter and result logic for the measurement loop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ps_d       = ps_q;
    mm_d       = mm_q;
    dist_d     = dist_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    timeout_d  = timeout_q;
    w_to_evt   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (run) state_d = ST_TRIG;
      end

      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_RISE: begin
        if (w_to_hit) begin
          w_to_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (w_rise) begin
            state_d = ST_MEASURE;
            ps_d    = PS_RISE;
            mm_d    = MM_RISE;
          end
        end
      end

      ST_MEASURE: begin
        // A falling edge coinciding with the timeout still yields a distance.
        if (w_fall) begin
          dist_d     = mm_q;
          in_range_d = (mm_q >= MIN_V) && (mm_q <= MAX_V);
          timeout_d  = 1'b0;
          valid_d    = 1'b1;
          state_d    = ST_HOLDOFF;
          cnt_d      = '0;
        end else if (w_to_hit) begin
          w_to_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (echo_s_q) begin
            if (ps_q == PS_LAST) begin
              ps_d = '0;
              if (mm_q != MM_SAT) mm_d = mm_q + 12'd1;
            end else begin
              ps_d = ps_q + PS_ONE;
            end
          end
        end
      end

      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = run ? ST_TRIG : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (w_to_evt) begin
      timeout_d = 1'b1;
      valid_d   = 1'b1;
      state_d   = ST_HOLDOFF;
      cnt_d     = '0;
`ifdef SONAR_HOLD_LAST_EN
      dist_d     = dist_q;
      in_range_d = in_range_q;
`else
      dist_d     = MM_SAT;
      in_range_d = 1'b0;
`endif
    end

    trig_d = (state_d == ST_TRIG);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ps_q       <= '0;
      mm_q       <= '0;
      dist_q     <= '0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ps_q       <= ps_d;
      mm_q       <= mm_d;
      dist_q     <= dist_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      timeout_q  <= timeout_d;
    end
  end

  assign trig       = trig_q;
  assign dist_mm    = dist_q;
  assign dist_valid = valid_q;
  assign in_range   = in_range_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sonar_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sonar_sequencer
// Description : Self-checking bench for sonar_sequencer: table of fixed echo
//               patterns, randomised echo patterns against a reference model,
//               and hand-written run-drop and reset-during-trigger sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonar_sequencer;

  localparam int TRIG = 10;
  localparam int CPM  = 4;
  localparam int TO   = 200;
  localparam int HOLD = 50;
  localparam int MINV = 2;
  localparam int MAXV = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [11:0] dist_mm;
  logic        dist_valid;
  logic        in_range;
  logic        timeout;
  logic        busy;

  int total = 0;
  int bad = 0;
  int m_dist = 0;
  int m_inr = 0;

  typedef struct {
    int s;        // stale echo cycles held after trig falls (0 = none)
    int d;        // low cycles before the measured pulse
    int w;        // measured pulse width in cycles (0 = no echo)
    int e_dist;
    int e_inr;
    int e_to;
  } vec_t;

  sonar_sequencer #(
    .TRIG_CYCLES   (TRIG),
    .CYCLES_PER_MM (CPM),
    .ECHO_TIMEOUT  (TO),
    .HOLDOFF_CYCLES(HOLD),
    .MIN_MM        (MINV),
    .MAX_MM        (MAXV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .echo      (echo),
    .trig      (trig),
    .dist_mm   (dist_mm),
    .dist_valid(dist_valid),
    .in_range  (in_range),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: distance is the pulse width divided by cycles-per-mm,
  // saturating; no pulse means a timeout.
  task automatic model_step(input int w, output int ed, output int er, output int et);
    if (w == 0) begin
      et = 1;
`ifndef SONAR_HOLD_LAST_EN
      m_dist = 4095;
      m_inr  = 0;
`endif
    end else begin
      et     = 0;
      m_dist = w / CPM;
      if (m_dist > 4095) m_dist = 4095;
      m_inr  = (m_dist >= MINV && m_dist <= MAXV) ? 1 : 0;
    end
    ed = m_dist;
    er = m_inr;
  endtask

  // Waits for a trigger, drives one echo pattern after it and returns at the
  // negedge on which dist_valid is seen.
  task automatic do_meas(input int s, input int d, input int w, input bit drop,
                         output int rw, output int tlen, output int lat, output bit ok);
    ok = 1'b1; rw = 0; tlen = 0; lat = 0;
    while (trig !== 1'b1 && rw < 1000) begin @(negedge clk); rw++; end
    if (trig !== 1'b1) begin ok = 1'b0; return; end
    if (s > 0) echo = 1'b1;
    while (trig === 1'b1 && tlen < 100) begin tlen++; @(negedge clk); end
    if (s > 0) begin
      repeat (s) begin @(negedge clk); lat++; end
      echo = 1'b0;
    end
    repeat (d) begin @(negedge clk); lat++; end
    if (w > 0) begin
      echo = 1'b1;
      for (int i = 0; i < w; i++) begin
        @(negedge clk); lat++;
        if (drop && i == w / 2) run = 1'b0;
      end
      echo = 1'b0;
    end
    while (dist_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
    if (dist_valid !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int ed, er, et, rw, tlen, lat, h, tseen;
    int rs, rd, rwid;
    bit ok;

    tbl[0] = '{0, 3,  40, 10, 1, 0};
`ifdef SONAR_HOLD_LAST_EN
    tbl[1] = '{0, 0,   0, 10, 1, 1};
`else
    tbl[1] = '{0, 0,   0, 4095, 0, 1};
`endif
    tbl[2] = '{0, 2,   4,  1, 0, 0};
    tbl[3] = '{0, 0, 124, 31, 0, 0};
    tbl[4] = '{0, 1,   8,  2, 1, 0};
    tbl[5] = '{0, 1, 123, 30, 1, 0};
    tbl[6] = '{0, 4,   3,  0, 0, 0};
    tbl[7] = '{5, 5,  20,  5, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trig",     int'(trig), 0);
    check("rst_busy",     int'(busy), 0);
    check("rst_dist",     int'(dist_mm), 0);
    check("rst_valid",    int'(dist_valid), 0);
    check("rst_in_range", int'(in_range), 0);
    check("rst_timeout",  int'(timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;

    // Fixed patterns
    foreach (tbl[i]) begin
      model_step(tbl[i].w, ed, er, et);
      do_meas(tbl[i].s, tbl[i].d, tbl[i].w, 1'b0, rw, tlen, lat, ok);
      check($sformatf("v%0d_done", i), int'(ok), 1);
      check($sformatf("v%0d_trig_wait", i), rw, (i == 0) ? 1 : HOLD);
      check($sformatf("v%0d_trig_len", i), tlen, TRIG);
      check($sformatf("v%0d_dist", i), int'(dist_mm), tbl[i].e_dist);
      check($sformatf("v%0d_in_range", i), int'(in_range), tbl[i].e_inr);
      check($sformatf("v%0d_timeout", i), int'(timeout), tbl[i].e_to);
      if (i == 0) check("v0_busy", int'(busy), 1);
      if (tbl[i].w == 0) check($sformatf("v%0d_to_latency", i), lat, TO);
    end

    // Randomised patterns against the reference model
    for (int n = 0; n < 16; n++) begin
      rwid = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 160));
      rs   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      rd   = int'($urandom_range(0, 20));
      if (rs > 0 && rd == 0) rd = 1;
      model_step(rwid, ed, er, et);
      do_meas(rs, rd, rwid, 1'b0, rw, tlen, lat, ok);
      check($sformatf("r%0d_done", n), int'(ok), 1);
      check($sformatf("r%0d_trig_wait", n), rw, HOLD);
      check($sformatf("r%0d_dist(w=%0d)", n, rwid), int'(dist_mm), ed);
      check($sformatf("r%0d_in_range", n), int'(in_range), er);
      check($sformatf("r%0d_timeout", n), int'(timeout), et);
      if (rwid == 0) check($sformatf("r%0d_to_latency", n), lat, TO);
    end

    // run dropped mid-measurement: finish, hold off, go idle, no new trigger
    model_step(40, ed, er, et);
    do_meas(0, 2, 40, 1'b1, rw, tlen, lat, ok);
    check("drop_done", int'(ok), 1);
    check("drop_dist", int'(dist_mm), 10);
    check("drop_timeout", int'(timeout), 0);
    h = 0;
    do begin
      @(negedge clk); h++;
      if (h == 1) check("valid_one_cycle", int'(dist_valid), 0);
    end while (busy === 1'b1 && h < 200);
    check("holdoff_len", h, HOLD);
    tseen = 0;
    repeat (60) begin @(negedge clk); if (trig === 1'b1) tseen = 1; end
    check("no_retrigger", tseen, 0);
    check("idle_busy", int'(busy), 0);

    // Reset asserted during TRIG clears everything at once
    run = 1'b1;
    rw = 0;
    while (trig !== 1'b1 && rw < 10) begin @(negedge clk); rw++; end
    check("idle_trig_wait", rw, 1);
    repeat (3) @(negedge clk);
    check("pre_rst_trig", int'(trig), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trig",     int'(trig), 0);
    check("arst_busy",     int'(busy), 0);
    check("arst_dist",     int'(dist_mm), 0);
    check("arst_in_range", int'(in_range), 0);
    check("arst_timeout",  int'(timeout), 0);
    check("arst_valid",    int'(dist_valid), 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sonar_sequencer.md
# sonar_sequencer

Measurement sequencer for the HC‑SR04 ultrasonic ranger on the robot. Schedules trigger pulses, times the echo, converts echo width to millimetres without a divider, and publishes a distance word plus strobe to the display and motor‑control logic. Replaces the free‑running trigger counter with a handshaked, timeout‑protected measurement loop.

## Interface
Parameters:
- `TRIG_CYCLES`, 500: trigger high time in clk cycles (10 µs at 50 MHz).
- `CYCLES_PER_MM`, 291: clk cycles of echo per mm of distance (round trip, 343 m/s, 50 MHz).
- `ECHO_TIMEOUT`, 1250000: max cycles from trigger fall to echo fall (25 ms).
- `HOLDOFF_CYCLES`, 3000000: dead time after each measurement (60 ms).
- `MIN_MM`, 20 / `MAX_MM`, 4000: valid range bounds, inclusive.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active‑low reset.
- `run` in 1: level; 1 = measure continuously.
- `echo` in 1: raw sensor echo, asynchronous to clk.
- `trig` out 1: sensor trigger.
- `dist_mm` out 12: last distance, mm.
- `dist_valid` out 1: one‑cycle strobe, `dist_mm` updated.
- `in_range` out 1: `MIN_MM` ≤ `dist_mm` ≤ `MAX_MM` and last result not a timeout.
- `timeout` out 1: last measurement timed out.
- `busy` out 1: state ≠ IDLE.

## Operation
- `echo` passes through a 2‑FF synchronizer; one more register gives `echo_q` for edge detection.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: `run`=1 → TRIG; trig counter cleared.
- TRIG: `trig`=1 for exactly `TRIG_CYCLES` cycles → WAIT_RISE; timeout counter cleared.
- WAIT_RISE: synced rising edge (`echo_s`=1, `echo_q`=0) → MEASURE, prescaler and mm counter cleared. A stale high echo on entry is not an edge; the state waits for low, then high.
- MEASURE: while synced echo high, prescaler counts 0..`CYCLES_PER_MM`−1; on wrap the mm counter increments, saturating at 4095. Synced falling edge → latch mm counter into `dist_mm`, `timeout`=0, pulse `dist_valid`, → HOLDOFF.
- Timeout counter runs in WAIT_RISE and MEASURE. Reaching `ECHO_TIMEOUT` → `dist_mm`=4095, `timeout`=1, pulse `dist_valid`, → HOLDOFF.
- HOLDOFF: count `HOLDOFF_CYCLES`, then → TRIG if `run`=1, else IDLE.
- `run` dropping mid‑measurement does not abort; the current measurement and holdoff complete.
- `in_range` is registered, updated with `dist_mm`.
- Reset: all outputs 0 (`dist_mm`=0, `trig`=0, `in_range`=0, `timeout`=0, `busy`=0), state IDLE, synchronizer cleared. Asserting `rst_n` mid‑trigger drops `trig` immediately.

## Timing
- `trig` rises 1 cycle after `run` is sampled high in IDLE.
- Echo edge seen by FSM 3 cycles after the pin edge. The measured width equals the pin width within ±1 cycle.
- `dist_mm` = floor(width_cycles / `CYCLES_PER_MM`), saturating at 4095.
- `dist_valid` and the new `dist_mm`/`timeout`/`in_range` all appear in the same cycle, 1 cycle after the synced falling edge (or the timeout hit).
- Trigger period with `run` held high = `TRIG_CYCLES` + echo phase + `HOLDOFF_CYCLES` + 1 (IDLE→TRIG only on first).
- Timeout and falling edge in the same cycle: the falling edge wins (valid distance).

## Configuration
- `SONAR_HOLD_LAST_EN` defined: on timeout, `dist_mm` and `in_range` keep their previous values; `timeout`=1 and `dist_valid` still pulse.
- Not defined: on timeout, `dist_mm`=4095 and `in_range`=0, as above.

## Test plan
Bench parameters: `TRIG_CYCLES`=10, `CYCLES_PER_MM`=4, `ECHO_TIMEOUT`=200, `HOLDOFF_CYCLES`=50, `MIN_MM`=2, `MAX_MM`=30.
- Reset, then `run`=1 → `trig` high exactly 10 cycles, 1 cycle after `run`; `busy`=1.
- Echo high 40 cycles → `dist_valid` pulse, `dist_mm`=10, `in_range`=1, `timeout`=0.
- No echo → `dist_valid` 200 cycles after `trig` falls, `timeout`=1. Without the macro, `dist_mm`=4095. With `SONAR_HOLD_LAST_EN`, `dist_mm` holds the previous value 10.
- Echo high 4 cycles → `dist_mm`=1, `in_range`=0. Echo high 124 cycles → `dist_mm`=31, `in_range`=0.
- Echo already high when WAIT_RISE is entered, falls, then rises for 20 cycles → `dist_mm`=5 (the stale pulse is ignored).
- `run` dropped during MEASURE → measurement completes, holdoff runs 50 cycles, then IDLE with no new `trig`. `rst_n` asserted during TRIG → `trig`=0 immediately, all outputs 0.
